// File: rtl/signed_div_seq_v_pkg.sv
// Shared defaults, FSM encoding and saturation helper for the signed divide/multiply blocks.
package signed_div_seq_v_pkg;

    localparam int unsigned DIVIDEND_W_DEF = 9;
    localparam int unsigned DIVISOR_W_DEF  = 5;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StSign = 2'd2
    } state_e;

    // Largest positive two's-complement value of width w; used when -2^(w-1) / -1 overflows.
    function automatic logic [31:0] sat_max(input int unsigned w);
        return (32'd1 << (w - 32'd1)) - 32'd1;
    endfunction

endpackage

// File: rtl/signed_mag_v.sv
// Conditional two's-complement negate: res = neg ? -val : val.
module signed_mag_v #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/signed_div_seq_v.sv
// Sequential signed divider: restoring division on magnitudes, one quotient bit per clock,
// followed by a sign-correction cycle. Quotient truncates toward zero.
module signed_div_seq_v
    import signed_div_seq_v_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int unsigned DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [DIVIDEND_W-1:0] i_dividend,
    input  logic [DIVISOR_W-1:0]  i_divisor,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DIVIDEND_W-1:0] o_quot,
    output logic [DIVISOR_W-1:0]  o_rem,
    output logic                  o_div_zero,
    output logic                  o_ovf
);

    localparam int unsigned CNT_W = $clog2(DIVIDEND_W);
    localparam logic [DIVIDEND_W-1:0] QUOT_SAT = DIVIDEND_W'(sat_max(DIVIDEND_W));
    localparam logic [DIVIDEND_W-1:0] DVD_MIN  = {1'b1, {(DIVIDEND_W-1){1'b0}}};

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    // Dividend magnitude shifts out of the top while quotient bits shift in at the bottom.
    logic [DIVIDEND_W-1:0] acc_q, acc_d;
    logic [DIVISOR_W-1:0]  dvs_mag_q, dvs_mag_d;
    logic [DIVISOR_W:0]    prem_q, prem_d;
    logic                  quot_neg_q, quot_neg_d;
    logic                  rem_neg_q, rem_neg_d;
    logic                  op_dz_q, op_dz_d;
    logic                  op_ovf_q, op_ovf_d;

    logic [DIVIDEND_W-1:0] quot_q, quot_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic                  dz_q, dz_d;
    logic                  ovf_q, ovf_d;
    logic                  done_q, done_d;

    logic [DIVIDEND_W-1:0] dvd_mag;
    logic [DIVISOR_W-1:0]  dvs_mag;
    logic [DIVIDEND_W-1:0] quot_signed;
    logic [DIVISOR_W-1:0]  rem_signed;
    logic [DIVISOR_W:0]    prem_shift;
    logic [DIVISOR_W:0]    trial;
    logic                  fits;
    logic                  unused_prem_msb;

    signed_mag_v #(.W(DIVIDEND_W)) u_dvd_mag (
        .val (i_dividend),
        .neg (i_dividend[DIVIDEND_W-1]),
        .res (dvd_mag)
    );

    signed_mag_v #(.W(DIVISOR_W)) u_dvs_mag (
        .val (i_divisor),
        .neg (i_divisor[DIVISOR_W-1]),
        .res (dvs_mag)
    );

    signed_mag_v #(.W(DIVIDEND_W)) u_quot_fix (
        .val (acc_q),
        .neg (quot_neg_q),
        .res (quot_signed)
    );

    signed_mag_v #(.W(DIVISOR_W)) u_rem_fix (
        .val (prem_q[DIVISOR_W-1:0]),
        .neg (rem_neg_q),
        .res (rem_signed)
    );

    // The settled remainder is always below |divisor| <= 2^(W-1), so its top bit is spare.
    assign unused_prem_msb = prem_q[DIVISOR_W];

    assign prem_shift = {prem_q[DIVISOR_W-1:0], acc_q[DIVIDEND_W-1]};
    assign trial      = prem_shift - {1'b0, dvs_mag_q};
    assign fits       = (prem_shift >= {1'b0, dvs_mag_q});

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        dvs_mag_d  = dvs_mag_q;
        prem_d     = prem_q;
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;
        op_dz_d    = op_dz_q;
        op_ovf_d   = op_ovf_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dz_d       = dz_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d    = StCalc;
                    cnt_d      = CNT_W'(DIVIDEND_W - 1);
                    acc_d      = dvd_mag;
                    dvs_mag_d  = dvs_mag;
                    prem_d     = '0;
                    quot_neg_d = i_dividend[DIVIDEND_W-1] ^ i_divisor[DIVISOR_W-1];
                    rem_neg_d  = i_dividend[DIVIDEND_W-1];
                    op_dz_d    = (i_divisor == '0);
                    op_ovf_d   = (i_dividend == DVD_MIN) && (i_divisor == '1);
                end
            end
            StCalc: begin
                prem_d = fits ? trial : prem_shift;
                acc_d  = {acc_q[DIVIDEND_W-2:0], fits};
                if (cnt_q == '0) begin
                    state_d = StSign;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StSign: begin
                state_d = StIdle;
                done_d  = 1'b1;
                dz_d    = op_dz_q;
                ovf_d   = op_ovf_q;
                if (op_dz_q) begin
                    quot_d = '0;
                    rem_d  = '0;
                end else if (op_ovf_q) begin
                    quot_d = QUOT_SAT;
                    rem_d  = '0;
                end else begin
                    quot_d = quot_signed;
                    rem_d  = rem_signed;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            dvs_mag_q  <= '0;
            prem_q     <= '0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            op_dz_q    <= 1'b0;
            op_ovf_q   <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            dz_q       <= 1'b0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            dvs_mag_q  <= dvs_mag_d;
            prem_q     <= prem_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
            op_dz_q    <= op_dz_d;
            op_ovf_q   <= op_ovf_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dz_q       <= dz_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    assign o_busy     = (state_q != StIdle);
    assign o_done     = done_q;
    assign o_quot     = quot_q;
    assign o_rem      = rem_q;
    assign o_div_zero = dz_q;
    assign o_ovf      = ovf_q;

endmodule

// File: tb/tb_signed_div_seq_v.sv
// Self-checking bench for signed_div_seq_v: spec vectors, handshake corner cases,
// randomized operands against an integer-arithmetic reference, and a (a*b)/b round trip.
module tb_signed_div_seq_v;

    typedef struct packed {
        logic [8:0] q;
        logic [4:0] r;
        logic       dz;
        logic       ovf;
    } res_t;

    typedef struct packed {
        logic [8:0] a;
        logic [4:0] b;
        res_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_start;
    logic [8:0] i_dividend;
    logic [4:0] i_divisor;
    logic       o_busy;
    logic       o_done;
    logic [8:0] o_quot;
    logic [4:0] o_rem;
    logic       o_div_zero;
    logic       o_ovf;

    int   n_chk = 0;
    int   n_err = 0;
    res_t last_exp;

    always #5 clk = ~clk;

    signed_div_seq_v dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_dividend (i_dividend),
        .i_divisor  (i_divisor),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_quot     (o_quot),
        .o_rem      (o_rem),
        .o_div_zero (o_div_zero),
        .o_ovf      (o_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain signed integer division, truncating toward zero.
    function automatic res_t model(input logic [8:0] a, input logic [4:0] b);
        res_t r;
        int   sa;
        int   sb;
        sa = $signed(a);
        sb = $signed(b);
        if (sb == 0) begin
            r = '{q: 9'd0, r: 5'd0, dz: 1'b1, ovf: 1'b0};
        end else if (sa == -256 && sb == -1) begin
            r = '{q: 9'h0FF, r: 5'd0, dz: 1'b0, ovf: 1'b1};
        end else begin
            r.q   = 9'(sa / sb);
            r.r   = 5'(sa % sb);
            r.dz  = 1'b0;
            r.ovf = 1'b0;
        end
        return r;
    endfunction

    // One operation from the accepted start edge to o_done. poke > 0 re-asserts i_start
    // before that edge while busy, which must have no effect.
    task automatic do_op(input logic [8:0] a, input logic [4:0] b, input res_t exp,
                         input int poke);
        int    lat;
        bit    gap;
        string tag;
        tag = $sformatf("%0d/%0d", $signed(a), $signed(b));
        i_dividend = a;
        i_divisor  = b;
        i_start    = 1'b1;
        tick();
        i_start = 1'b0;
        chk({"busy_after_start ", tag}, 32'(o_busy), 32'd1);
        chk({"hold_prev ", tag}, {o_quot, o_rem, o_div_zero, o_ovf, o_done}, {last_exp, 1'b0});
        i_dividend = 9'($urandom);
        i_divisor  = 5'($urandom);
        lat = 0;
        gap = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            i_start = (k == poke);
            tick();
            if (o_done) begin
                lat = k;
                break;
            end
            if (!o_busy) gap = 1'b1;
        end
        i_start = 1'b0;
        chk({"latency ", tag}, 32'(lat), 32'd10);
        chk({"busy_gap ", tag}, 32'(gap), 32'd0);
        chk({"busy_at_done ", tag}, 32'(o_busy), 32'd0);
        chk({"quot ", tag}, 32'(o_quot), 32'(exp.q));
        chk({"rem ", tag}, 32'(o_rem), 32'(exp.r));
        chk({"flags ", tag}, {o_div_zero, o_ovf}, {exp.dz, exp.ovf});
        last_exp = exp;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[10];
        bit   done_seen;
        res_t e;

        tbl[0] = {9'd100,  5'd7,    9'h00E, 5'h02, 1'b0, 1'b0};
        tbl[1] = {9'h19C,  5'd7,    9'h1F2, 5'h1E, 1'b0, 1'b0};
        tbl[2] = {9'h0FF,  5'h10,   9'h1F1, 5'h0F, 1'b0, 1'b0};
        tbl[3] = {9'h100,  5'h1F,   9'h0FF, 5'h00, 1'b0, 1'b1};
        tbl[4] = {9'd37,   5'd0,    9'h000, 5'h00, 1'b1, 1'b0};
        tbl[5] = {9'd77,   5'h1A,   9'h1F4, 5'h05, 1'b0, 1'b0};
        tbl[6] = {9'h1F9,  5'd2,    9'h1FD, 5'h1F, 1'b0, 1'b0};
        tbl[7] = {9'd7,    5'h1E,   9'h1FD, 5'h01, 1'b0, 1'b0};
        tbl[8] = {9'h1F1,  5'h10,   9'h000, 5'h11, 1'b0, 1'b0};
        tbl[9] = {9'd0,    5'd3,    9'h000, 5'h00, 1'b0, 1'b0};

        last_exp   = '0;
        i_rst      = 1'b1;
        i_start    = 1'b0;
        i_dividend = '0;
        i_divisor  = '0;
        repeat (3) tick();
        chk("reset_outputs", {o_busy, o_done, o_quot, o_rem, o_div_zero, o_ovf}, 32'd0);
        i_rst = 1'b0;
        tick();
        chk("idle_after_reset", {o_busy, o_done}, 32'd0);

        // Spec vectors, run back to back: each start lands in the previous o_done cycle.
        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].exp, 0);
        end

        // Extra start with new operands mid-operation is ignored.
        do_op(9'd50, 5'd5, {9'd10, 5'd0, 1'b0, 1'b0}, 3);
        do_op(9'h1CE, 5'd9, {9'h1FB, 5'h1B, 1'b0, 1'b0}, 9);

        // Reset mid-operation: outputs clear and no done for the aborted op.
        i_dividend = 9'd123;
        i_divisor  = 5'd4;
        i_start    = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (4) tick();
        i_rst = 1'b1;
        tick();
        chk("abort_outputs", {o_busy, o_done, o_quot, o_rem, o_div_zero, o_ovf}, 32'd0);
        i_rst     = 1'b0;
        done_seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (o_done || o_busy) done_seen = 1'b1;
        end
        chk("no_done_after_abort", 32'(done_seen), 32'd0);
        last_exp = '0;

        // Randomized operands against the reference model.
        for (int i = 0; i < 200; i++) begin
            logic [8:0] a;
            logic [4:0] b;
            a = 9'($urandom);
            b = 5'($urandom);
            do_op(a, b, model(a, b), 0);
        end

        // Round trip: (a*b)/b must give back a exactly when a*b fits the dividend.
        for (int a = -16; a <= 15; a++) begin
            for (int b = -16; b <= 15; b++) begin
                int p;
                p = a * b;
                if (b != 0 && p >= -256 && p <= 255) begin
                    e = '{q: 9'(a), r: 5'd0, dz: 1'b0, ovf: 1'b0};
                    do_op(9'(p), 5'(b), e, 0);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
